rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 115 +++++++++++
 tb/tb_rr_arbiter4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin arbiter with registered one-hot grant
// Optional grant-hold timeout is compiled in when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter4 #(
   parameter int         TIMEOUT  = 15,
   parameter logic [1:0] PTR_INIT = 2'd3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy
`ifdef RR_ARB_TIMEOUT_EN
   ,
   output logic       timeout
`endif
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     state, state_next;
   logic [1:0] ptr;
   logic [1:0] cand;
   logic [1:0] winner;
   logic       found;
   logic       release_hit;
   logic       expire;

   generate
      if (TIMEOUT < 1) begin : g_bad_timeout
         $error("rr_arbiter4: TIMEOUT must be at least 1");
      end
   endgenerate

   // Highest priority sits at ptr and decreases modulo 4.
   always_comb begin
      found  = 1'b0;
      winner = 2'd0;
      cand   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         cand = ptr - 2'(k);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign release_hit = done || !req[gnt_id] || !en;

`ifdef RR_ARB_TIMEOUT_EN
   localparam int         CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

   logic [CW-1:0] cnt;

   // A normal release on the same edge wins over the timeout.
   assign expire = (state == GRANT) && (cnt == TO_MAX) && !release_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= expire;
         if (state == IDLE && state_next == GRANT)
            cnt <= CW'(1);
         else if (state_next == IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
      end
   end
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (en && found) state_next = GRANT;
         GRANT:   if (release_hit || expire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt    <= 4'b0000;
         gnt_id <= 2'd0;
         ptr    <= PTR_INIT;
      end else if (state == IDLE && state_next == GRANT) begin
         gnt    <= 4'b0001 << winner;
         gnt_id <= winner;
         ptr    <= winner - 2'd1;
      end else if (state == GRANT && state_next == IDLE) begin
         gnt    <= 4'b0000;
         gnt_id <= 2'd0;
      end
   end

   always_comb begin
      busy = (state == GRANT);
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - scoreboard bench for rr_arbiter4 with a distance-based priority model
// Drives directed scenarios then random traffic; a monitor checks every cycle's outputs.
module tb_rr_arbiter4;

   localparam int TMO = 4;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       to;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
`ifdef RR_ARB_TIMEOUT_EN
   logic       timeout;
`endif

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   bit   m_busy;
   int   m_id;
   int   m_ptr;
   int   m_cnt;
   bit   m_to;

   rr_arbiter4 #(.TIMEOUT(TMO), .PTR_INIT(2'd3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .req    (req),
      .done   (done),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .busy   (busy)
`ifdef RR_ARB_TIMEOUT_EN
      ,
      .timeout(timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Winner is the requester closest below-or-at ptr, measured as (ptr - i) mod 4.
   function automatic int pick(input int p, input logic [3:0] r);
      int best;
      int bestd;
      best  = 0;
      bestd = 99;
      for (int i = 0; i < 4; i++) begin
         if (r[i] && ((p - i + 4) % 4) < bestd) begin
            bestd = (p - i + 4) % 4;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic model_step();
      exp_t e;
      bit   leave;
      if (m_busy) begin
         leave = done || !req[m_id] || !en;
         m_to  = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
         if (!leave && m_cnt == TMO) m_to = 1'b1;
`endif
         if (leave || m_to) m_busy = 1'b0;
         else               m_cnt++;
      end else begin
         m_to = 1'b0;
         if (en && req != 4'b0000) begin
            m_id   = pick(m_ptr, req);
            m_busy = 1'b1;
            m_ptr  = (m_id + 3) % 4;
            m_cnt  = 1;
         end
      end
      e.gnt  = m_busy ? 4'(1 << m_id) : 4'b0000;
      e.id   = m_busy ? 2'(m_id) : 2'd0;
      e.busy = m_busy;
      e.to   = m_to;
      sb.push_back(e);
   endtask

   task automatic drive(input logic e, input logic [3:0] r, input logic d);
      en   = e;
      req  = r;
      done = d;
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_gnt", int'(gnt), 0);
      check("rst_gnt_id", int'(gnt_id), 0);
      check("rst_busy", int'(busy), 0);
`ifdef RR_ARB_TIMEOUT_EN
      check("rst_timeout", int'(timeout), 0);
`endif
      m_busy = 1'b0;
      m_id   = 0;
      m_ptr  = 3;
      m_cnt  = 0;
      m_to   = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check("gnt", int'(gnt), int'(e.gnt));
            check("gnt_id", int'(gnt_id), int'(e.id));
            check("busy", int'(busy), int'(e.busy));
`ifdef RR_ARB_TIMEOUT_EN
            check("timeout", int'(timeout), int'(e.to));
`endif
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b1;
      en    = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      #1;
      do_reset();

      // priority after reset and rotation with done pulses
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'b1111, 1'b0);
         drive(1'b1, 4'b1111, 1'b1);
      end
      drive(1'b1, 4'b1111, 1'b1);

      // release by request drop, done ignored in IDLE
      do_reset();
      drive(1'b1, 4'b0010, 1'b0);
      drive(1'b1, 4'b0010, 1'b0);
      drive(1'b1, 4'b0000, 1'b0);
      drive(1'b1, 4'b0000, 1'b1);

      // enable gating
      do_reset();
      for (int i = 0; i < 3; i++) drive(1'b0, 4'b0011, 1'b0);
      drive(1'b1, 4'b0011, 1'b0);
      drive(1'b1, 4'b0011, 1'b0);
      drive(1'b0, 4'b0011, 1'b0);
      drive(1'b0, 4'b0011, 1'b0);

      // reset mid-grant restores the pointer
      do_reset();
      drive(1'b1, 4'b1110, 1'b0);
      drive(1'b1, 4'b1110, 1'b0);
      drive(1'b1, 4'b0100, 1'b0);
      drive(1'b1, 4'b0100, 1'b0);
      do_reset();
      drive(1'b1, 4'b1111, 1'b0);
      drive(1'b1, 4'b1111, 1'b1);

      // long hold, then a release on the fourth grant cycle
      do_reset();
      for (int i = 0; i < 7; i++) drive(1'b1, 4'b0001, 1'b0);
      drive(1'b1, 4'b0000, 1'b0);
      drive(1'b1, 4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'b0001, 1'b0);
      drive(1'b1, 4'b0001, 1'b1);
      drive(1'b0, 4'b0000, 1'b0);

      // random traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         drive(($urandom_range(0, 7) != 0),
               4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0));
      end

      drive(1'b0, 4'b0000, 1'b0);
      @(posedge clk);
      #2;
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
